// File: rtl/brc_issue_queue_pkg.sv
// Shared execute/resolve types for the branch issue queue: operand width,
// comparator functions and the packed queue entry.
package brc_issue_queue_pkg;

  localparam int XLEN     = 32;
  localparam int IQ_TAG_W = 5;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic            bool;

  localparam bool TRUE  = 1'b1;
  localparam bool FALSE = 1'b0;

  typedef enum logic [2:0] {
    BRC_BEQ  = 3'd0,
    BRC_BNE  = 3'd1,
    BRC_BLT  = 3'd2,
    BRC_BGE  = 3'd3,
    BRC_BLTU = 3'd4,
    BRC_BGEU = 3'd5,
    BRC_JUMP = 3'd6
  } brc_fun_t;

  typedef struct packed {
    brc_fun_t                     fun;
    xlen_t [1:0]                  ops;
    logic  [1:0]                  rdy;
    logic  [1:0][IQ_TAG_W-1:0]    src_tag;
    logic  [IQ_TAG_W-1:0]         rob_tag;
    xlen_t                        pc;
    xlen_t                        target;
    logic                         pred_taken;
  } brc_iq_entry_t;

endpackage

// File: rtl/brc_issue_queue_if.sv
// Dispatch, result-broadcast and resolution signals of the branch issue queue.
// The queue itself uses the slave modport.
interface brc_issue_queue_if
  import brc_issue_queue_pkg::*;
#(
  parameter int TAG_W = IQ_TAG_W
);
  logic                   flush;
  logic                   enq_valid;
  logic                   enq_ready;
  brc_fun_t               enq_fun;
  xlen_t [1:0]            enq_ops;
  logic  [1:0]            enq_rdy;
  logic  [1:0][TAG_W-1:0] enq_src_tag;
  logic  [TAG_W-1:0]      enq_rob_tag;
  xlen_t                  enq_pc;
  xlen_t                  enq_target;
  logic                   enq_pred_taken;
  logic                   cdb_valid;
  logic  [TAG_W-1:0]      cdb_tag;
  xlen_t                  cdb_data;
  logic                   res_valid;
  logic                   res_ready;
  logic  [TAG_W-1:0]      res_rob_tag;
  logic                   res_taken;
  logic                   res_mispredict;
  xlen_t                  res_redirect;

  modport master (
    output flush, enq_valid, enq_fun, enq_ops, enq_rdy, enq_src_tag, enq_rob_tag,
           enq_pc, enq_target, enq_pred_taken, cdb_valid, cdb_tag, cdb_data, res_ready,
    input  enq_ready, res_valid, res_rob_tag, res_taken, res_mispredict, res_redirect
  );

  modport slave (
    input  flush, enq_valid, enq_fun, enq_ops, enq_rdy, enq_src_tag, enq_rob_tag,
           enq_pc, enq_target, enq_pred_taken, cdb_valid, cdb_tag, cdb_data, res_ready,
    output enq_ready, res_valid, res_rob_tag, res_taken, res_mispredict, res_redirect
  );

endinterface

// File: rtl/brc_issue_queue_brc.sv
// Branch comparator: purely combinational verdict for one micro-op.
module brc
  import brc_issue_queue_pkg::*;
(
  input  logic     valid,
  input  brc_fun_t fun,
  input  xlen_t    op_a,
  input  xlen_t    op_b,
  output logic     taken
);

  always_comb begin
    taken = 1'b0;
    if (valid) begin
      case (fun)
        BRC_BEQ:  taken = (op_a == op_b);
        BRC_BNE:  taken = (op_a != op_b);
        BRC_BLT:  taken = ($signed(op_a) <  $signed(op_b));
        BRC_BGE:  taken = ($signed(op_a) >= $signed(op_b));
        BRC_BLTU: taken = (op_a <  op_b);
        BRC_BGEU: taken = (op_a >= op_b);
        BRC_JUMP: taken = 1'b1;
        default:  taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/brc_issue_queue.sv
// Collapsing branch issue queue: captures operands from the CDB, issues the
// oldest ready entry through the comparator and registers the resolution.
module brc_issue_queue
  import brc_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = IQ_TAG_W
)(
  input  logic              clk,
  input  logic              rst_n,
  brc_issue_queue_if.slave  io
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  brc_iq_entry_t    entries_q [DEPTH];
  brc_iq_entry_t    entries_d [DEPTH];
  brc_iq_entry_t    woken     [DEPTH];
  brc_iq_entry_t    incoming;
  brc_iq_entry_t    sel_entry;
  cnt_t             count_q, count_d;
  cnt_t             sel_idx, enq_slot;
  bool              sel_found, issue, enq_fire, enq_ready;
  logic             brc_taken;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic [TAG_W-1:0] res_rob_tag_q, res_rob_tag_d;
  xlen_t            res_redirect_q, res_redirect_d;

  function automatic brc_iq_entry_t wake(input brc_iq_entry_t e, input logic cv,
                                         input logic [TAG_W-1:0] ct, input xlen_t cd);
    brc_iq_entry_t w;
    w = e;
    for (int k = 0; k < 2; k++) begin
      if (!e.rdy[k] && cv && (e.src_tag[k] == ct)) begin
        w.ops[k] = cd;
        w.rdy[k] = 1'b1;
      end
    end
    return w;
  endfunction

  // Scan downward so the lowest (oldest) ready index wins.
  function automatic cnt_t oldest_ready(input brc_iq_entry_t q [DEPTH], input cnt_t cnt,
                                        output bool found);
    cnt_t idx;
    idx   = '0;
    found = FALSE;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((cnt_t'(i) < cnt) && (q[i].rdy == 2'b11)) begin
        idx   = cnt_t'(i);
        found = TRUE;
      end
    end
    return idx;
  endfunction

  always_comb begin
    sel_found = FALSE;
    sel_idx   = oldest_ready(entries_q, count_q, sel_found);
    sel_entry = entries_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_t'(i) == sel_idx) sel_entry = entries_q[i];
    end
    issue     = sel_found && (!res_valid_q || io.res_ready);
    enq_ready = (count_q < cnt_t'(DEPTH));
    enq_fire  = io.enq_valid && enq_ready;
    enq_slot  = count_q - cnt_t'(issue);
  end

  brc u_brc (
    .valid (sel_found),
    .fun   (sel_entry.fun),
    .op_a  (sel_entry.ops[0]),
    .op_b  (sel_entry.ops[1]),
    .taken (brc_taken)
  );

  always_comb begin
    incoming            = '0;
    incoming.fun        = io.enq_fun;
    incoming.ops        = io.enq_ops;
    incoming.rdy        = io.enq_rdy;
    incoming.src_tag    = io.enq_src_tag;
    incoming.rob_tag    = io.enq_rob_tag;
    incoming.pc         = io.enq_pc;
    incoming.target     = io.enq_target;
    incoming.pred_taken = io.enq_pred_taken;
    incoming            = wake(incoming, io.cdb_valid, io.cdb_tag, io.cdb_data);

    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = wake(entries_q[i], io.cdb_valid, io.cdb_tag, io.cdb_data);
    end

    // Entries above the issued slot collapse down, carrying this cycle's wakeups.
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = woken[i];
      if (issue && (cnt_t'(i) >= sel_idx)) entries_d[i] = woken[(i < DEPTH - 1) ? i + 1 : i];
      if (enq_fire && (cnt_t'(i) == enq_slot)) entries_d[i] = incoming;
    end
    count_d = count_q + cnt_t'(enq_fire) - cnt_t'(issue);

    res_valid_d      = res_valid_q;
    res_rob_tag_d    = res_rob_tag_q;
    res_taken_d      = res_taken_q;
    res_mispredict_d = res_mispredict_q;
    res_redirect_d   = res_redirect_q;
    if (issue) begin
      res_valid_d      = 1'b1;
      res_rob_tag_d    = sel_entry.rob_tag;
      res_taken_d      = brc_taken;
      res_mispredict_d = (brc_taken != sel_entry.pred_taken);
      res_redirect_d   = brc_taken ? sel_entry.target : sel_entry.pc + xlen_t'(4);
    end else if (io.res_ready) begin
      res_valid_d = 1'b0;
    end

    if (io.flush) begin
      count_d     = '0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      count_q          <= '0;
      res_valid_q      <= 1'b0;
      res_rob_tag_q    <= '0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_redirect_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      count_q          <= count_d;
      res_valid_q      <= res_valid_d;
      res_rob_tag_q    <= res_rob_tag_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      res_redirect_q   <= res_redirect_d;
    end
  end

  assign io.enq_ready      = enq_ready;
  assign io.res_valid      = res_valid_q;
  assign io.res_rob_tag    = res_rob_tag_q;
  assign io.res_taken      = res_taken_q;
  assign io.res_mispredict = res_mispredict_q;
  assign io.res_redirect   = res_redirect_q;

endmodule

// File: doc/brc_issue_queue.md
# brc_issue_queue

Branch issue queue and scheduler for the single branch comparator (`brc`). It buffers up to `DEPTH` decoded branch/jump micro-ops and captures missing operands from the result broadcast bus. Each cycle it selects the oldest entry whose operands are both ready, drives it through one `brc` instance, and registers the resolution (taken, mispredict, redirect target) for the commit/redirect logic. It sits between dispatch and the front-end redirect path.

## Interface
- `DEPTH`, 4: queue entries; ≥2.
- `TAG_W`, 5: ROB/physical tag width.
- `clk` input 1: clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of all entries and the result stage.
- `enq_valid` input 1: dispatch offers a branch micro-op.
- `enq_ready` output 1: queue not full.
- `enq_fun` input `brc_fun_t`: comparator function.
- `enq_ops` input `xlen_t [1:0]`: operand values, meaningful where `enq_rdy` is set.
- `enq_rdy` input 2: per-operand ready.
- `enq_src_tag` input `[1:0][TAG_W]`: producer tags for non-ready operands.
- `enq_rob_tag` input `TAG_W`: branch identity.
- `enq_pc` and `enq_target` input `xlen_t`: branch PC and computed taken-target.
- `enq_pred_taken` input 1: front-end prediction.
- `cdb_valid`, `cdb_tag`, `cdb_data` input 1/`TAG_W`/`xlen_t`: result broadcast bus.
- `res_valid` output 1: resolution valid.
- `res_ready` input 1: consumer accepts the resolution.
- `res_rob_tag` output `TAG_W`: branch identity.
- `res_taken` output 1: comparator verdict.
- `res_mispredict` output 1: `res_taken != pred_taken`.
- `res_redirect` output `xlen_t`: `res_taken ? target : pc + 4` (modulo 2^XLEN).

## Operation
- Storage is a collapsing queue. Entry 0 is the oldest, and valid entries are contiguous from 0. Each entry holds fun, ops, rdy[1:0], src_tag, rob_tag, pc, target and pred_taken.
- **Wakeup:** for every valid entry and operand with rdy=0, `cdb_valid && cdb_tag == src_tag` loads `cdb_data` into the operand and sets rdy at the edge.
- **Enqueue bypass:** the same CDB compare is applied to incoming operands, so an operand produced in the enqueue cycle is captured.
- **Select:** the lowest-index valid entry with rdy == 2'b11 is selected. The selection uses registered state only; a wakeup in the current cycle makes the entry eligible next cycle.
- **Issue:** the selected entry's ops and fun drive `brc` with `valid` set.
  - Issue occurs when a candidate exists and the result stage is free: `!res_valid || res_ready`.
  - On issue, the result stage loads the outputs, the entry is removed, and entries above it shift down one slot. Their wakeups are applied during the shift.
- **Enqueue:** accepted when `enq_valid && enq_ready`. The new entry is written to slot `count`, or to `count-1` if an issue occurs in the same cycle.
- **Full flag:** `enq_ready = (count < DEPTH)` from registered count. No same-cycle credit is given for an issue.
- **Result stage:** holds its value while `res_valid && !res_ready`, and clears when accepted with no new issue.
- **Flush:** has priority over enqueue, issue and wakeup. At the next edge, all entries are invalid, count = 0 and `res_valid` = 0. Inputs presented in the flush cycle are dropped.

## Timing
- Reset (async, `rst_n` low):
  - count = 0 and all entries invalid.
  - `res_valid` = 0 and the other res_* outputs = 0.
  - `enq_ready` = 1 once count is 0, i.e. during reset.
- Enqueue with both operands ready at edge N: issue in cycle N+1, `res_valid` from edge N+2. The enqueue-to-result latency is 2 cycles.
- CDB wakeup at edge N: issue in cycle N+1, result at edge N+2.
- Issue rate is at most one per cycle. With `res_ready` held high, back-to-back results are produced every cycle.
- Reset asserted mid-operation discards everything immediately and asynchronously.

## Structure
- Shared package (existing execute/resolve headers): `brc_fun_t`, `xlen_t`, `bool`/TRUE/FALSE. Add `brc_iq_entry_t` as a packed struct of the entry fields.
- Sub-module: the existing `brc` instance. The oldest-ready select should be a small local priority encoder function, not a separate module.

## Test plan
- **Ready enqueue:** enqueue BEQ with ops 5/5, both ready, pred 0, pc 0x100 → 2 cycles later `res_taken`=1, `res_mispredict`=1, `res_redirect`=target.
- **Wakeup and age order:**
  - Enqueue A (BLT, op1 waits on tag 3), then B (BNE 1/2, ready).
  - Expect B to resolve first.
  - Then send `cdb_tag`=3 with data 0xFFFFFFFF. A (ops 0 vs -1) resolves with taken=0 and redirect = pc+4.
- **Fill and backpressure:**
  - Fill 4 entries. `enq_ready` drops to 0 and a fifth enqueue is not accepted.
  - Hold `res_ready`=0: the result stays stable and no entry issues.
  - Release `res_ready`: 4 results emerge on consecutive cycles in age order.
- **Same-cycle events:**
  - Enqueue in the same cycle as a CDB broadcast of the incoming operand's tag → the operand is captured.
  - Enqueue while the oldest entry issues → the new entry lands directly above the shifted entries.
- **Flush:** flush with 3 entries and `res_valid`=1 → next cycle count=0, `res_valid`=0, `enq_ready`=1, and the enqueue presented in the flush cycle is absent.
- **Reset and jump:**
  - Assert `rst_n`=0 mid-stream → outputs are zero asynchronously.
  - After release, a JUMP with unready operands still waits for readiness, then resolves with taken=1.
